// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control unit for the 16-bit datapath.
// It walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes and the program counter, and counts retired instructions.
// Optional build macro CTRL_SINGLE_STEP_EN adds a 'step' input that gates
// FETCH so the sequencer advances one instruction per step pulse.
module control_sequencer #(
  parameter logic [15:0] PC_RESET = 16'd0,
  parameter logic [15:0] PC_STEP  = 16'd1,
  parameter logic [15:0] PC_LAST  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [1:0]  opcode,
  output logic [15:0] pcFill,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUOp,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] OP_R    = 2'b00;
  localparam logic [1:0] OP_LW   = 2'b01;
  localparam logic [1:0] OP_SW   = 2'b10;
  localparam logic [1:0] OP_ADDI = 2'b11;

  state_t     st;
  logic [1:0] op_q;        // opcode captured in DECODE, used until retire
  logic       fetch_go;    // FETCH may advance this cycle
  logic       is_mem_op;   // current instruction visits MEM
  state_t     after_retire;

  // Static decode bundle {RegDst, ALUSrc, MemToReg, ALUOp} for one opcode.
  function automatic logic [3:0] static_decode(input logic [1:0] op);
    logic [3:0] d;
    d = 4'b0000;
    case (op)
      OP_R:    d = 4'b1001;
      OP_LW:   d = 4'b0110;
      OP_SW:   d = 4'b0100;
      OP_ADDI: d = 4'b0101;
      default: d = 4'b0000;
    endcase
    return d;
  endfunction

  // Retired counter increments but sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef CTRL_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  assign is_mem_op = (op_q == OP_LW) || (op_q == OP_SW);
  assign state     = st;

  // Where the sequencer goes once the current instruction retires; the last
  // address wins over run so the program end is always honoured.
  always_comb begin
    after_retire = S_IDLE;
    if (pcFill == PC_LAST) begin
      after_retire = S_HALT;
    end else if (run) begin
      after_retire = S_FETCH;
    end
  end

  // Instruction sequencer with registered strobes; each strobe is set on the
  // edge that enters its state and cleared on the edge that leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      op_q     <= OP_R;
      pcFill   <= PC_RESET;
      retired  <= 16'd0;
      RegDst   <= 1'b0;
      ALUSrc   <= 1'b0;
      MemToReg <= 1'b0;
      ALUOp    <= 1'b0;
      RegWrite <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (run) begin
            st <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (fetch_go) begin
            st <= S_DECODE;
          end
        end

        // The only place opcode is looked at.
        S_DECODE: begin
          op_q <= opcode;
          {RegDst, ALUSrc, MemToReg, ALUOp} <= static_decode(opcode);
          st <= S_EXEC;
        end

        S_EXEC: begin
          if (is_mem_op) begin
            MemRead  <= (op_q == OP_LW);
            MemWrite <= (op_q == OP_SW);
            st       <= S_MEM;
          end else begin
            RegWrite <= 1'b1;
            st       <= S_WB;
          end
        end

        S_MEM: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          if (op_q == OP_LW) begin
            RegWrite <= 1'b1;
            st       <= S_WB;
          end else begin
            // Store retires straight out of MEM.
            pcFill   <= pcFill + PC_STEP;
            retired  <= sat_inc(retired);
            {RegDst, ALUSrc, MemToReg, ALUOp} <= 4'b0000;
            st       <= after_retire;
          end
        end

        S_WB: begin
          RegWrite <= 1'b0;
          pcFill   <= pcFill + PC_STEP;
          retired  <= sat_inc(retired);
          {RegDst, ALUSrc, MemToReg, ALUOp} <= 4'b0000;
          st       <= after_retire;
        end

        // Sticky until reset; everything stays quiet.
        S_HALT: begin
          RegWrite <= 1'b0;
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          {RegDst, ALUSrc, MemToReg, ALUOp} <= 4'b0000;
        end

        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. Two instances share stimulus:
// one with the default last address, one with PC_LAST=13 for the halt case.
module tb_control_sequencer;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       run    = 1'b0;
  logic [1:0] opcode = 2'b00;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step   = 1'b0;
`endif

  logic [15:0] pc_a, ret_a, pc_h, ret_h;
  logic [2:0]  st_a, st_h;
  logic rd_a, as_a, mtr_a, rw_a, mr_a, mw_a, ao_a;
  logic rd_h, as_h, mtr_h, rw_h, mr_h, mw_h, ao_h;

  always #5 clk = ~clk;

  control_sequencer #(.PC_RESET(16'd11), .PC_STEP(16'd1), .PC_LAST(16'hFFFF)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .opcode(opcode), .pcFill(pc_a), .RegDst(rd_a), .ALUSrc(as_a),
    .MemToReg(mtr_a), .RegWrite(rw_a), .MemRead(mr_a), .MemWrite(mw_a),
    .ALUOp(ao_a), .state(st_a), .retired(ret_a)
  );

  control_sequencer #(.PC_RESET(16'd11), .PC_STEP(16'd1), .PC_LAST(16'd13)) dut_h (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .opcode(opcode), .pcFill(pc_h), .RegDst(rd_h), .ALUSrc(as_h),
    .MemToReg(mtr_h), .RegWrite(rw_h), .MemRead(mr_h), .MemWrite(mw_h),
    .ALUOp(ao_h), .state(st_h), .retired(ret_h)
  );

  // Observed-instance selection: 0 = dut_a, 1 = dut_h.
  logic        sel = 1'b0;
  logic [2:0]  obs_state;
  logic [15:0] obs_pc, obs_ret;
  logic [6:0]  obs_ctrl;   // {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,ALUOp}
  assign obs_state = sel ? st_h  : st_a;
  assign obs_pc    = sel ? pc_h  : pc_a;
  assign obs_ret   = sel ? ret_h : ret_a;
  assign obs_ctrl  = sel ? {rd_h, as_h, mtr_h, rw_h, mr_h, mw_h, ao_h}
                         : {rd_a, as_a, mtr_a, rw_a, mr_a, mw_a, ao_a};

  int checks   = 0;
  int failures = 0;

  // Reference model: expected address, retire count and program end.
  logic [15:0] m_pc, m_ret, m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected strobe vector for an opcode while in phase ph (1..5).
  function automatic logic [6:0] exp_ctrl(input logic [1:0] op, input int ph);
    logic [3:0] s;   // {RegDst, ALUSrc, MemToReg, ALUOp}
    case (op)
      2'b00:   s = 4'b1001;
      2'b01:   s = 4'b0110;
      2'b10:   s = 4'b0100;
      default: s = 4'b0101;
    endcase
    if (ph < 3) return 7'b0;
    return {s[3], s[2], s[1], (ph == 5), (ph == 4 && op == 2'b01),
            (ph == 4 && op == 2'b10), s[0]};
  endfunction

  // Runs one instruction, starting at a negedge with the DUT in FETCH.
  task automatic exec_instr(input logic [1:0] op, input bit drop_in_exec);
    int ph[$];
    logic [15:0] old_pc;
    int exp_next;
    ph = {1, 2, 3};
    if (op == 2'b01) begin
      ph.push_back(4);
      ph.push_back(5);
    end else if (op == 2'b10) begin
      ph.push_back(4);
    end else begin
      ph.push_back(5);
    end
    foreach (ph[i]) begin
      check("state", 32'(obs_state), 32'(ph[i]));
      check("ctrl", 32'(obs_ctrl), 32'(exp_ctrl(op, ph[i])));
      check("pc", 32'(obs_pc), 32'(m_pc));
      check("retired", 32'(obs_ret), 32'(m_ret));
      opcode = (ph[i] == 2) ? op : 2'($urandom);
`ifdef CTRL_SINGLE_STEP_EN
      step = (ph[i] == 1);
`endif
      if (drop_in_exec && ph[i] == 3) run = 1'b0;
      @(negedge clk);
    end
    old_pc = m_pc;
    m_pc   = m_pc + 16'd1;
    if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
    exp_next = (old_pc == m_last) ? 6 : (run ? 1 : 0);
    check("next_state", 32'(obs_state), 32'(exp_next));
    check("pc_retire", 32'(obs_pc), 32'(m_pc));
    check("ret_retire", 32'(obs_ret), 32'(m_ret));
    check("ctrl_retire", 32'(obs_ctrl), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; m_last = 16'hFFFF; m_pc = 16'd11; m_ret = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(obs_state), 32'd0);
    check("rst_pc", 32'(obs_pc), 32'd11);
    check("rst_ret", 32'(obs_ret), 32'd0);
    check("rst_ctrl", 32'(obs_ctrl), 32'd0);

    // IDLE holds while run is low.
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_hold", 32'(obs_state), 32'd0);
    run = 1'b1;
    @(negedge clk);
    check("idle_to_fetch", 32'(obs_state), 32'd1);

    // addi, lw, sub, add, sll, sw from address 11.
    exec_instr(2'b11, 1'b0);
    check("pc_after_addi", 32'(obs_pc), 32'd12);
    exec_instr(2'b01, 1'b0);
    exec_instr(2'b00, 1'b0);
    exec_instr(2'b00, 1'b0);
    exec_instr(2'b00, 1'b0);
    exec_instr(2'b10, 1'b0);
    check("pc_after_seq", 32'(obs_pc), 32'd17);
    check("ret_after_seq", 32'(obs_ret), 32'd6);

    // Random instruction mix.
    repeat (20) exec_instr(2'($urandom), 1'b0);

    // Drop run during EXEC of a load: it completes, then parks in IDLE.
    exec_instr(2'b01, 1'b1);
    repeat (3) begin
      opcode = 2'($urandom);
      @(negedge clk);
      check("idle_after_drop", 32'(obs_state), 32'd0);
      check("pc_idle", 32'(obs_pc), 32'(m_pc));
    end
    run = 1'b1;
    @(negedge clk);
    check("resume_fetch", 32'(obs_state), 32'd1);

    // Asynchronous reset while a store sits in MEM.
    opcode = 2'($urandom);
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    @(negedge clk);
    opcode = 2'b10;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif
    @(negedge clk);
    opcode = 2'($urandom);
    @(negedge clk);
    check("sw_mem_state", 32'(obs_state), 32'd4);
    check("sw_memwrite", 32'(obs_ctrl), 32'(exp_ctrl(2'b10, 4)));
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctrl", 32'(obs_ctrl), 32'd0);
    check("arst_state", 32'(obs_state), 32'd0);
    check("arst_pc", 32'(obs_pc), 32'd11);
    check("arst_ret", 32'(obs_ret), 32'd0);

    // Halt after retiring address 13.
    sel = 1'b1; m_last = 16'd13; m_pc = 16'd11; m_ret = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    check("h_fetch", 32'(obs_state), 32'd1);
    repeat (3) exec_instr(2'b00, 1'b0);
    repeat (8) begin
      run    = 1'($urandom);
      opcode = 2'($urandom);
      @(negedge clk);
      check("halt_state", 32'(obs_state), 32'd6);
      check("halt_pc", 32'(obs_pc), 32'd14);
      check("halt_ret", 32'(obs_ret), 32'd3);
      check("halt_ctrl", 32'(obs_ctrl), 32'd0);
    end

`ifdef CTRL_SINGLE_STEP_EN
    // Parking in FETCH without step, then one pulse retires one instruction.
    sel = 1'b0; m_last = 16'hFFFF; m_pc = 16'd11; m_ret = 16'd0;
    rst_n = 1'b0; step = 1'b0; run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("step_park", 32'(obs_state), 32'd1);
      check("step_park_ret", 32'(obs_ret), 32'd0);
    end
    exec_instr(2'($urandom), 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("step_repark", 32'(obs_state), 32'd1);
      check("step_one_ret", 32'(obs_ret), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
